// File: rtl/matmul_pkg.sv
// Shared constants, FSM state type and index helper
// for the 3x3 matrix multiply-accumulate engine.
package matmul_pkg;

  localparam int DATA_W        = 8;
  localparam int DIM           = 3;
  localparam int ACC_W         = 2*DATA_W+2;
  localparam int BYTES_PER_RES = 3;
  localparam int MAT_W         = DIM*DIM*DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    EMIT,
    DONE
  } state_t;

  function automatic logic [3:0] elem_idx(
    input logic [1:0] row,
    input logic [1:0] col
  );
    return {2'b00, row} * 4'd3 + {2'b00, col};
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Single 8x8 unsigned multiply-accumulate with clear/enable.
// Ports: clk, reset, clr, en, a, b -> acc (ACC_W bits).
module mac_unit
  import matmul_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic [2*DATA_W-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/matrix_mac_engine.sv
// Snapshots A,B on start edge, computes C=AxB with one MAC,
// streams 9x3 result bytes LSB first over valid/ready.
// Ports: clk, reset, start, a_mat, b_mat, out_ready ->
//        out_data, out_valid, out_last, busy, done.
module matrix_mac_engine
  import matmul_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [MAT_W-1:0] a_mat,
  input  logic [MAT_W-1:0] b_mat,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] LAST_IDX = 2'(DIM-1);
  localparam logic [1:0] LAST_B   = 2'(BYTES_PER_RES-1);

  state_t state_q, state_d;
  logic [1:0] i_q, j_q, k_q, b_q;
  logic start_q, start_rise;
  logic [MAT_W-1:0] a_snap, b_snap;
  logic [DATA_W-1:0] a_el [DIM*DIM];
  logic [DATA_W-1:0] b_el [DIM*DIM];
  logic [DATA_W-1:0] op_a, op_b;
  logic [ACC_W-1:0] acc;
  logic mac_clr, mac_en, snap_ld;
  logic last_k, last_b, last_elem;
  logic [7:0] byte_sel;

  for (genvar g = 0; g < DIM*DIM; g++) begin : g_unpack
    assign a_el[g] = a_snap[DATA_W*g +: DATA_W];
    assign b_el[g] = b_snap[DATA_W*g +: DATA_W];
  end

  assign op_a = a_el[elem_idx(i_q, k_q)];
  assign op_b = b_el[elem_idx(k_q, j_q)];

  assign start_rise = start & ~start_q;
  assign last_k     = (k_q == LAST_IDX);
  assign last_b     = (b_q == LAST_B);
  assign last_elem  = (i_q == LAST_IDX) && (j_q == LAST_IDX);

  mac_unit u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     (op_a),
    .b     (op_b),
    .acc   (acc)
  );

  always_comb begin
    state_d = state_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    snap_ld = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_rise) begin
          snap_ld = 1'b1;
          mac_clr = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (last_k) state_d = EMIT;
      end
      EMIT: begin
        if (out_ready && last_b) begin
          mac_clr = 1'b1;
          state_d = last_elem ? DONE : MAC;
        end
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      a_snap  <= '0;
      b_snap  <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      if (snap_ld) begin
        a_snap <= a_mat;
        b_snap <= b_mat;
        i_q    <= '0;
        j_q    <= '0;
        k_q    <= '0;
        b_q    <= '0;
      end
      if (state_q == MAC) begin
        k_q <= last_k ? 2'd0 : k_q + 2'd1;
        b_q <= '0;
      end
      if (state_q == EMIT && out_ready) begin
        if (last_b) begin
          b_q <= '0;
          if (j_q == LAST_IDX) begin
            j_q <= '0;
            i_q <= i_q + 2'd1;
          end else begin
            j_q <= j_q + 2'd1;
          end
        end else begin
          b_q <= b_q + 2'd1;
        end
      end
    end
  end

  // top byte zero-pads the 2 MSBs of the 18-bit result
  always_comb begin
    byte_sel = '0;
    unique case (b_q)
      2'd0:    byte_sel = acc[7:0];
      2'd1:    byte_sel = acc[15:8];
      default: byte_sel = {6'b0, acc[17:16]};
    endcase
  end

  assign out_valid = (state_q == EMIT);
  assign out_data  = out_valid ? byte_sel : 8'h00;
  assign out_last  = out_valid && last_elem && last_b;
  assign busy      = (state_q == MAC) || (state_q == EMIT);
  assign done      = (state_q == DONE);

endmodule

// File: doc/matrix_mac_engine.md
Name: matrix_mac_engine

Overview:
Downstream consumer of the 3x3 operand loader. Snapshots two unsigned 3x3 byte matrices A and B when the loader raises its done flag, then computes C = A x B with a single time-shared 8x8 multiply-accumulate unit. Streams the nine 18-bit results out as bytes over an 8-bit valid/ready interface toward the chip output pins.

Parameters:
DATA_W, 8, operand element width in bits (unsigned)
DIM, 3, matrix dimension; the block is specified and verified only at 3
ACC_W, 2*DATA_W+2, accumulator width (18); holds DIM products without overflow
BYTES_PER_RES, 3, output bytes per result element, equal to ceil(ACC_W/8)

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  level from the loader's done output; a rising edge launches one computation
a_mat  input  72  A row-major; element A[i][k] at bits [8*(3i+k)+7 : 8*(3i+k)]
b_mat  input  72  B row-major; same packing as a_mat
out_data  output  8  current result byte
out_valid  output  1  out_data holds a valid byte
out_ready  input  1  downstream accepts the byte; a transfer occurs on out_valid & out_ready
out_last  output  1  high with the final byte of C[2][2]
busy  output  1  high from accepted start through the last transfer
done  output  1  all 27 bytes transferred; held until start goes low

Behaviour:
- Reset (async, active-high): state=IDLE, out_data=0, out_valid=0, out_last=0, busy=0, done=0, acc=0, indices i,j,k=0, byte index=0, start_q=0, snapshot registers=0.
- start_q registers start every cycle. start_rise = start & ~start_q. A level held high never retriggers.
- IDLE: on start_rise, copy a_mat and b_mat into internal snapshot registers, clear acc, i=j=k=0, set busy=1, then go to MAC. The snapshot isolates the block from later changes on the inputs.
- MAC: one product per cycle, acc <= acc + A[i][k]*B[k][j], computed unsigned and zero-extended to ACC_W. k steps 0 to 2. After k=2, go to EMIT with byte index=0. Exactly 3 cycles per element.
- EMIT: out_valid=1 and out_data = acc[8b+7:8b] for byte index b, LSB first; byte 2 carries {6'b0, acc[17:16]}.
  - out_data and out_valid are stable while out_valid=1 and out_ready=0.
  - On a transfer, b increments. After b=2 transfers, advance to the next element in row-major order (j first, then i), clear acc, and return to MAC.
  - After C[2][2] completes, go to DONE.
- out_last=1 only during EMIT with i=2, j=2, b=2.
- DONE: out_valid=0, busy=0, done=1. When start=0, go to IDLE, clear done, and wait for the next rising edge.
- With out_ready held at 1, the first byte is valid 4 cycles after the start_rise cycle. A full computation takes 54 cycles (9 elements x (3 MAC + 3 EMIT)).
- A start_rise while busy or done is ignored.
- Asserting reset mid-operation aborts immediately to reset values; no partial output is sent afterwards.
- out_valid never drops without a transfer, except on reset.

Decomposition:
- Package matmul_pkg holds:
  - DATA_W, DIM and ACC_W constants
  - the state enum typedef {IDLE, MAC, EMIT, DONE}
  - an elem_idx(row, col) function returning 3*row+col
- One natural sub-module: mac_unit. It holds the multiply-add and the accumulator register, with clear/enable inputs, and is shared across all nine elements.

Test Plan:
- A = 1..9 and B = 9..1 row-major, out_ready=1, pulse start -> bytes C00 = 1E,00,00 arrive first and C22 = 5A,00,00 arrive last with out_last=1. Total 54 cycles, then done=1.
- A = B = all 0xFF -> every element is 195075 = 0x2FA03. The stream is (03,FA,02) repeated 9 times.
- A = identity, B = 1..9, with out_ready toggling pseudo-randomly -> the byte stream equals B zero-extended, with no drops or duplicates. out_data is stable while stalled.
- Hold start high for 100 cycles after completion, change a_mat mid-run -> exactly one result stream computed from the snapshot values. done stays 1 until start falls; a new start edge then repeats the computation.
- Assert reset during EMIT of element 4 -> all outputs are 0 on the next sample. A fresh start edge yields a correct full stream.
